// File: rtl/skid_buffer_fifo.sv
// DEPTH-entry valid/ready elastic buffer with registered s_ready, m_valid,
// m_data and count, so neither interface sees a combinational path from the other.
module skid_buffer_fifo #(
  parameter int WORD_WIDTH  = 64,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WORD_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORD_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0]       PTR_ZERO   = PTR_W'(0);
  localparam logic [PTR_W-1:0]       PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [WORD_WIDTH-1:0]  DATA_ZERO  = WORD_WIDTH'(0);

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  logic [WORD_WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   s_ready_q, s_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic [WORD_WIDTH-1:0]  m_data_q, m_data_d;
  logic                   push_s;
  logic                   pop_s;

  assign push_s = s_valid & s_ready_q;
  assign pop_s  = m_valid_q & m_ready;

  // Next-state: pointers, occupancy, flags and the head-of-buffer register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_data_d  = m_data_q;

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    // The incoming word becomes the head directly when nothing older remains.
    if (push_s && ((count_q == COUNT_ZERO) || (pop_s && (count_q == COUNT_ONE)))) begin
      m_data_d = s_data;
    end else if (pop_s && (count_q > COUNT_ONE)) begin
      m_data_d = mem_q[ptr_inc(rd_ptr_q)];
    end else begin
      m_data_d = m_data_q;
    end

    s_ready_d = (count_d != COUNT_FULL);
    m_valid_d = (count_d != COUNT_ZERO);
  end

  // Control and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= COUNT_ZERO;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= DATA_ZERO;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (push_s && !clear) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_skid_buffer_fifo.sv
// Scoreboard bench for skid_buffer_fifo: accepted words are queued and
// compared against m_data whenever the DUT hands a word downstream.
module tb_skid_buffer_fifo;

  localparam int WW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [WW-1:0] s_data = 64'd0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [WW-1:0] m_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] sb[$];
  logic          mon_en = 1'b0;
  logic          push_seen = 1'b0;
  int            pop_cnt = 0;
  int            push_cnt = 0;

  skid_buffer_fifo #(.WORD_WIDTH(WW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .clock   (clock),
    .clear   (clear),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Negedge monitor: inputs and registered outputs are stable here and
  // describe exactly what the next rising edge will do.
  always @(negedge clock) begin
    push_seen = 1'b0;
    if (mon_en) begin
      if (clear) begin
        sb.delete();
      end else begin
        check_eq("count_vs_sb", 64'(count), 64'(sb.size()));
        check_eq("m_valid_vs_sb", 64'(m_valid), 64'(sb.size() != 0));
        check_eq("s_ready_vs_sb", 64'(s_ready), 64'(sb.size() < DEPTH));
        if (sb.size() != 0) check_eq("m_data_head", m_data, sb[0]);
        if (m_valid && m_ready && sb.size() != 0) begin
          void'(sb.pop_front());
          pop_cnt++;
        end
        if (s_valid && s_ready) begin
          sb.push_back(s_data);
          push_seen = 1'b1;
          push_cnt++;
        end
      end
    end
  end

  logic [WW-1:0] words [4];
  logic [WW-1:0] held;
  logic [WW-1:0] src;
  int            max_cnt;
  int            bubbles;
  int            guard;

  initial begin
    words[0] = 64'hFEEDFACEDEADBEEF;
    words[1] = 64'hCAFEBABEABBABABE;
    words[2] = 64'h0123456789ABCDEF;
    words[3] = 64'h0000000000000001;

    // 1: reset with s_valid asserted
    #2;
    clear = 1'b1; s_valid = 1'b1; s_data = 64'h5555;
    tick(); tick();
    clear = 1'b0; s_valid = 1'b0;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
    check_eq("rst_m_data", m_data, 64'd0);
    mon_en = 1'b1;

    // 2: fill with downstream stalled, then drain
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = words[i];
      tick();
      check_eq("fill_accept", 64'(push_seen), 64'd1);
    end
    s_data = 64'h9999999999999999;
    tick();
    check_eq("fifth_rejected", 64'(push_seen), 64'd0);
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", m_data, words[i]);
      tick();
      check_eq("drain_count", 64'(count), 64'(3 - i));
    end
    check_eq("drain_m_valid", 64'(m_valid), 64'd0);

    // 3: streaming, one word per cycle
    pop_cnt = 0;
    m_ready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      s_valid = 1'b1; s_data = 64'(i);
      tick();
      check_eq("stream_accept", 64'(push_seen), 64'd1);
      check_eq("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      check_eq("stream_m_data", m_data, 64'(i));
    end
    s_valid = 1'b0;
    tick();
    check_eq("stream_pops", 64'(pop_cnt), 64'd12);
    check_eq("stream_empty", 64'(count), 64'd0);

    // 4: downstream stall mid-stream, source honours s_ready
    src = 64'd100; max_cnt = 0; bubbles = 0;
    s_valid = 1'b1; s_data = src; m_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      m_ready = (c >= 3 && c < 8) ? 1'b0 : 1'b1;
      if (c == 3) held = m_data;
      if (c > 3 && c < 8) check_eq("stall_hold", m_data, held);
      if (c >= 8 && !s_ready) bubbles++;
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (push_seen) begin
        src = src + 64'd1;
        s_data = src;
      end
    end
    check_eq("stall_max_count", 64'(max_cnt), 64'd4);
    check_eq("stall_bubbles", 64'(bubbles), 64'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) tick();
    check_eq("stall_drained", 64'(count), 64'd0);

    // 5: random stalls on both sides across several wraps
    push_cnt = 0; guard = 0;
    s_valid = 1'b0;
    while (push_cnt < 3 * DEPTH + 1 + 8 && guard < 400) begin
      if (!s_valid || push_seen) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = {$urandom, $urandom};
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    check_eq("rand_progress", 64'(push_cnt >= 3 * DEPTH + 1), 64'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) tick();
    check_eq("rand_drained", 64'(count), 64'd0);

    // 6: clear with three words resident
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 64'hDEAD0000 + 64'(i);
      tick();
    end
    check_eq("pre_clear_count", 64'(count), 64'd3);
    s_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("clr_count", 64'(count), 64'd0);
    check_eq("clr_m_valid", 64'(m_valid), 64'd0);
    check_eq("clr_s_ready", 64'(s_ready), 64'd1);
    s_valid = 1'b1; s_data = 64'hABBA0000ABBA0000;
    tick();
    s_valid = 1'b0;
    check_eq("clr_next_data", m_data, 64'hABBA0000ABBA0000);
    check_eq("clr_next_count", 64'(count), 64'd1);
    m_ready = 1'b1;
    tick();
    check_eq("clr_final_empty", 64'(m_valid), 64'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
